acc_multicycle_ctrl: RTL and testbench
======================================

Name: acc_multicycle_ctrl

Overview:
- Multi-cycle sequencer for the 3-bit-opcode accumulator datapath.
- Replaces the single-cycle decode so that one shared memory port serves both instruction fetch and operand access.
- Sequences fetch/decode/execute, handshakes with a variable-latency memory (req/ready), and flags a memory timeout.
- Drives the PC, IR, AC and ALU load/select controls of the existing datapath.

Parameters:
- TIMEOUT, 15, maximum wait cycles for mem_ready per access; 0 disables the timeout.
- CW, 4, width of the wait counter; must satisfy 2^CW > TIMEOUT.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  run request; acted on at its rising edge only.
- opcode  in  3  IR[7:5], valid from the DECODE state onward.
- zero_ac  in  1  AC==0 flag from the datapath.
- mem_ready  in  1  memory completes the current access this cycle.
- mem_req  out  1  memory access request.
- mem_we  out  1  1 = write (STORE); qualified by mem_req.
- adr_src  out  1  0 = PC drives the address, 1 = IR operand field.
- ld_ir  out  1  load IR from memory data.
- ld_pc  out  1  load PC.
- pc_src  out  2  00 = PC+1, 01 = IR target; 10/11 never driven.
- ld_ac  out  1  load AC.
- ac_src  out  2  00 = ALU, 01 = memory data, 10 = immediate.
- alu_op  out  1  0 = add, 1 = sub.
- busy  out  1  high in FETCH, DECODE and MEM.
- halted  out  1  high in HALT.
- mem_err  out  1  high in ERR.
- state_dbg  out  3  current state encoding.

Behaviour:
- Reset:
  - Asynchronous; immediate at any state, including mid-access.
  - Goes to IDLE; wait counter = 0; start_q = 0.
  - All outputs read 0.
  - An in-flight memory access is abandoned; memory side handles its own reset.
- States (encoding): IDLE=0, FETCH=1, DECODE=2, MEM=3, HALT=4, ERR=5. Codes 6/7 fall to IDLE.
- Start edge:
  - start_q is a registered copy of start.
  - start_rise = start & ~start_q.
- IDLE: start_rise -> FETCH.
- FETCH:
  - mem_req=1, adr_src=0, mem_we=0.
  - While mem_ready=0: counter increments.
  - If TIMEOUT != 0 and the counter reaches TIMEOUT with no ready -> ERR.
  - On mem_ready=1: same cycle ld_ir=1, ld_pc=1, pc_src=00; counter cleared; -> DECODE.
- DECODE (one cycle; opcode and zero_ac sampled here):
  - 000 LOAD, 001 STORE, 010 ADD, 011 SUB -> MEM.
  - 100 JMP: ld_pc=1, pc_src=01 -> FETCH.
  - 101 JZ: if zero_ac then ld_pc=1, pc_src=01; -> FETCH.
  - 110 LDI: ld_ac=1, ac_src=10 -> FETCH.
  - 111 HALT -> HALT.
- MEM:
  - mem_req=1, adr_src=1, mem_we=1 only for STORE.
  - opcode is held stable by the IR.
  - Same timeout rule as FETCH.
  - On mem_ready, completing the access this cycle:
    - LOAD: ld_ac=1, ac_src=01.
    - ADD: ld_ac=1, ac_src=00, alu_op=0.
    - SUB: ld_ac=1, ac_src=00, alu_op=1.
    - STORE: no AC load.
  - Then counter cleared; -> FETCH.
- HALT: halted=1; start_rise -> FETCH. The PC already points past HALT, so execution resumes at the next instruction.
- ERR: mem_err=1; mem_req=0; start_rise -> IDLE. The PC is not modified.
- Output decoding:
  - All control outputs are combinational from state, opcode, zero_ac and mem_ready.
  - ld_* and ld_pc assert for exactly one cycle per event.
  - alu_op is 0 whenever not SUB in MEM; every output has a defined value in every state, so no latches.
- Handshake:
  - mem_req stays high, with adr_src and mem_we stable, until the cycle mem_ready=1.
  - mem_ready outside FETCH/MEM is ignored.
- Latency with zero-wait memory:
  - LOAD/STORE/ADD/SUB: 3 cycles.
  - JMP/JZ/LDI: 2 cycles.
  - Each memory wait cycle adds 1.
- Simultaneous events:
  - mem_ready arriving in the same cycle the counter hits TIMEOUT counts as success.
  - start_rise while busy is ignored; start_q still updates.

Test Plan:
- Reset release, start 0->1, zero-wait memory, LOAD -> FETCH (cycle 1, ld_ir=ld_pc=1), DECODE (cycle 2), MEM (cycle 3, ld_ac=1, ac_src=01) -> back in FETCH at cycle 4.
- JZ with zero_ac=1 -> DECODE asserts ld_pc=1, pc_src=01. Repeat with zero_ac=0 -> ld_pc=0 in DECODE, next state FETCH.
- STORE with mem_ready delayed 3 cycles -> mem_req=1, mem_we=1, adr_src=1 held for 4 cycles; ld_ac never asserted.
- TIMEOUT=15, mem_ready held 0 in FETCH -> ERR entered after 15 wait cycles with mem_err=1. start pulse -> IDLE.
- mem_ready arriving exactly at wait count 15 -> no ERR; proceeds to DECODE.
- HALT opcode -> halted=1, start held high gives no exit. Drop then raise start -> FETCH next cycle.
- rst_n asserted mid-MEM with mem_req=1 -> all outputs 0 immediately, state_dbg=0.

Source files
------------

// File: rtl/acc_multicycle_ctrl.sv
// Multi-cycle fetch/decode/execute sequencer for the 3-bit-opcode accumulator
// datapath, sharing one variable-latency memory port with a wait timeout.
module acc_multicycle_ctrl #(
  parameter int unsigned TIMEOUT = 15,
  parameter int unsigned CW      = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [2:0] opcode,
  input  logic       zero_ac,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_we,
  output logic       adr_src,
  output logic       ld_ir,
  output logic       ld_pc,
  output logic [1:0] pc_src,
  output logic       ld_ac,
  output logic [1:0] ac_src,
  output logic       alu_op,
  output logic       busy,
  output logic       halted,
  output logic       mem_err,
  output logic [2:0] state_dbg
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_MEM    = 3'd3,
    S_HALT   = 3'd4,
    S_ERR    = 3'd5
  } state_e;

  typedef enum logic [2:0] {
    OP_LOAD  = 3'd0,
    OP_STORE = 3'd1,
    OP_ADD   = 3'd2,
    OP_SUB   = 3'd3,
    OP_JMP   = 3'd4,
    OP_JZ    = 3'd5,
    OP_LDI   = 3'd6,
    OP_HALT  = 3'd7
  } op_e;

  localparam logic [CW-1:0] TO = CW'(TIMEOUT);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          start_q;
  logic          start_rise;
  logic          wait_expired;
  op_e           op;

  assign op           = op_e'(opcode);
  assign start_rise   = start & ~start_q;
  // The cycle the counter sits at TIMEOUT is the last chance: ready there still wins.
  assign wait_expired = (TIMEOUT != 0) && (cnt_q == TO);
  assign state_dbg    = state_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      start_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      start_q <= start;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mem_req = 1'b0;
    mem_we  = 1'b0;
    adr_src = 1'b0;
    ld_ir   = 1'b0;
    ld_pc   = 1'b0;
    pc_src  = 2'b00;
    ld_ac   = 1'b0;
    ac_src  = 2'b00;
    alu_op  = 1'b0;
    busy    = 1'b0;
    halted  = 1'b0;
    mem_err = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start_rise) state_d = S_FETCH;
      end

      S_FETCH: begin
        busy    = 1'b1;
        mem_req = 1'b1;
        if (mem_ready) begin
          ld_ir   = 1'b1;
          ld_pc   = 1'b1;
          cnt_d   = '0;
          state_d = S_DECODE;
        end else if (wait_expired) begin
          cnt_d   = '0;
          state_d = S_ERR;
        end else if (TIMEOUT != 0) begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      S_DECODE: begin
        busy = 1'b1;
        case (op)
          OP_LOAD, OP_STORE, OP_ADD, OP_SUB: state_d = S_MEM;
          OP_JMP: begin
            ld_pc   = 1'b1;
            pc_src  = 2'b01;
            state_d = S_FETCH;
          end
          OP_JZ: begin
            ld_pc   = zero_ac;
            pc_src  = zero_ac ? 2'b01 : 2'b00;
            state_d = S_FETCH;
          end
          OP_LDI: begin
            ld_ac   = 1'b1;
            ac_src  = 2'b10;
            state_d = S_FETCH;
          end
          default: state_d = S_HALT;
        endcase
      end

      S_MEM: begin
        busy    = 1'b1;
        mem_req = 1'b1;
        adr_src = 1'b1;
        mem_we  = (op == OP_STORE);
        alu_op  = (op == OP_SUB);
        if (mem_ready) begin
          cnt_d   = '0;
          state_d = S_FETCH;
          case (op)
            OP_LOAD: begin
              ld_ac  = 1'b1;
              ac_src = 2'b01;
            end
            OP_ADD, OP_SUB: ld_ac = 1'b1;
            default: ld_ac = 1'b0;
          endcase
        end else if (wait_expired) begin
          cnt_d   = '0;
          state_d = S_ERR;
        end else if (TIMEOUT != 0) begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      S_HALT: begin
        halted = 1'b1;
        if (start_rise) state_d = S_FETCH;
      end

      S_ERR: begin
        mem_err = 1'b1;
        if (start_rise) state_d = S_IDLE;
      end

      default: begin
        cnt_d   = '0;
        state_d = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_acc_multicycle_ctrl.sv
// Self-checking bench for acc_multicycle_ctrl: per-cycle behavioural model
// comparison plus directed scenarios with hand-computed expectations.
module tb_acc_multicycle_ctrl;

  localparam int unsigned TO_CYC = 15;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [2:0] opcode;
  logic       zero_ac;
  logic       mem_ready;
  logic       mem_req, mem_we, adr_src, ld_ir, ld_pc, ld_ac, alu_op;
  logic       busy, halted, mem_err;
  logic [1:0] pc_src, ac_src;
  logic [2:0] state_dbg;
  logic [16:0] outs;

  int n_chk  = 0;
  int n_fail = 0;

  acc_multicycle_ctrl #(.TIMEOUT(TO_CYC), .CW(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .opcode(opcode),
    .zero_ac(zero_ac), .mem_ready(mem_ready), .mem_req(mem_req),
    .mem_we(mem_we), .adr_src(adr_src), .ld_ir(ld_ir), .ld_pc(ld_pc),
    .pc_src(pc_src), .ld_ac(ld_ac), .ac_src(ac_src), .alu_op(alu_op),
    .busy(busy), .halted(halted), .mem_err(mem_err), .state_dbg(state_dbg)
  );

  assign outs = {mem_req, mem_we, adr_src, ld_ir, ld_pc, pc_src, ld_ac,
                 ac_src, alu_op, busy, halted, mem_err, state_dbg};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: phase numbers follow the published state codes.
  localparam int P_IDLE = 0, P_FETCH = 1, P_DECODE = 2, P_MEM = 3, P_HALT = 4, P_ERR = 5;

  int   m_ph, m_w, m_nph, m_nw;
  logic m_sq, m_rise;

  function automatic logic [16:0] model_out(input int ph, input logic [2:0] op,
                                            input logic z, input logic rdy);
    logic       req, we, asrc, lir, lpc, lac, aop;
    logic [1:0] psrc, acs;
    logic       is_dec, is_mem;
    is_dec = (ph == P_DECODE);
    is_mem = (ph == P_MEM);
    req  = (ph == P_FETCH) || is_mem;
    we   = is_mem && (op == 3'd1);
    asrc = is_mem;
    lir  = (ph == P_FETCH) && rdy;
    lpc  = lir || (is_dec && ((op == 3'd4) || (op == 3'd5 && z)));
    psrc = (is_dec && lpc) ? 2'b01 : 2'b00;
    lac  = (is_dec && op == 3'd6) || (is_mem && rdy && op != 3'd1);
    acs  = (is_dec && op == 3'd6) ? 2'b10 :
           (is_mem && rdy && op == 3'd0) ? 2'b01 : 2'b00;
    aop  = is_mem && (op == 3'd3);
    return {req, we, asrc, lir, lpc, psrc, lac, acs, aop,
            (ph >= P_FETCH && ph <= P_MEM), (ph == P_HALT), (ph == P_ERR), 3'(ph)};
  endfunction

  assign m_rise = start & ~m_sq;

  always_comb begin
    m_nph = m_ph;
    m_nw  = m_w;
    if (m_ph == P_IDLE) begin
      if (m_rise) m_nph = P_FETCH;
    end else if (m_ph == P_FETCH || m_ph == P_MEM) begin
      if (mem_ready) begin
        m_nph = (m_ph == P_FETCH) ? P_DECODE : P_FETCH;
        m_nw  = 0;
      end else if (m_w == int'(TO_CYC)) begin
        m_nph = P_ERR;
        m_nw  = 0;
      end else begin
        m_nw = m_w + 1;
      end
    end else if (m_ph == P_DECODE) begin
      if (opcode < 3'd4)       m_nph = P_MEM;
      else if (opcode == 3'd7) m_nph = P_HALT;
      else                     m_nph = P_FETCH;
    end else if (m_ph == P_HALT) begin
      if (m_rise) m_nph = P_FETCH;
    end else if (m_ph == P_ERR) begin
      if (m_rise) m_nph = P_IDLE;
    end
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_ph <= P_IDLE;
      m_w  <= 0;
      m_sq <= 1'b0;
    end else begin
      m_ph <= m_nph;
      m_w  <= m_nw;
      m_sq <= start;
    end
  end

  always @(negedge clk) begin
    check("model_outputs", 32'(outs), 32'(model_out(m_ph, opcode, zero_ac, mem_ready)));
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  int n;
  int held;
  logic ac_seen;

  initial begin
    rst_n = 1'b0; start = 1'b0; opcode = 3'd0; zero_ac = 1'b0; mem_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
    check("reset_state", 32'(state_dbg), 32'd0);
    check("reset_outs", 32'(outs), 32'd0);

    // LOAD with zero-wait memory
    start = 1'b1;
    step(); mem_ready = 1'b1; #1;
    check("load_fetch", 32'({state_dbg, ld_ir, ld_pc, pc_src}), 32'({3'd1, 4'b1100}));
    step(); opcode = 3'd0; mem_ready = 1'b0; #1;
    check("load_decode", 32'(state_dbg), 32'd2);
    step(); mem_ready = 1'b1; #1;
    check("load_mem", 32'({state_dbg, ld_ac, ac_src}), 32'({3'd3, 3'b101}));
    step(); #1;
    check("load_back_fetch", 32'(state_dbg), 32'd1);

    // JZ taken, then not taken
    step(); opcode = 3'd5; zero_ac = 1'b1; mem_ready = 1'b0; #1;
    check("jz_taken", 32'({state_dbg, ld_pc, pc_src}), 32'({3'd2, 3'b101}));
    step(); mem_ready = 1'b1; #1;
    check("jz_taken_next", 32'(state_dbg), 32'd1);
    step(); zero_ac = 1'b0; mem_ready = 1'b0; #1;
    check("jz_not_taken", 32'({state_dbg, ld_pc, pc_src}), 32'({3'd2, 3'b000}));
    step(); #1;
    check("jz_nt_next", 32'(state_dbg), 32'd1);

    // STORE with 3 memory wait cycles
    mem_ready = 1'b1;
    step(); opcode = 3'd1; mem_ready = 1'b0;
    step();
    held = 0; ac_seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      mem_ready = (i == 3); #1;
      if (state_dbg == 3'd3 && mem_req && mem_we && adr_src) held++;
      ac_seen = ac_seen | ld_ac;
      step();
    end
    check("store_req_held", 32'(held), 32'd4);
    check("store_no_ld_ac", 32'(ac_seen), 32'd0);
    check("store_back_fetch", 32'(state_dbg), 32'd1);

    // Fetch timeout: 15 wait cycles, then the limit cycle without ready
    mem_ready = 1'b0; #1;
    n = 0;
    while (state_dbg == 3'd1 && n < 40) begin
      step();
      n++;
    end
    check("timeout_cycles", 32'(n), 32'd16);
    check("err_flags", 32'({state_dbg, mem_err, mem_req}), 32'({3'd5, 2'b10}));
    start = 1'b0; step();
    start = 1'b1; step();
    check("err_to_idle", 32'(state_dbg), 32'd0);

    // Ready arriving exactly at the limit count is a success
    start = 1'b0; step();
    start = 1'b1; step();
    repeat (15) step();
    mem_ready = 1'b1; #1;
    check("ready_at_limit", 32'({state_dbg, ld_ir}), 32'({3'd1, 1'b1}));
    step(); opcode = 3'd7; mem_ready = 1'b0; #1;
    check("no_err_decode", 32'(state_dbg), 32'd2);

    // HALT: held start does not exit; a fresh rising edge resumes
    step(); #1;
    check("halted", 32'({state_dbg, halted, busy}), 32'({3'd4, 2'b10}));
    repeat (3) step();
    check("halt_hold", 32'(state_dbg), 32'd4);
    start = 1'b0; step();
    start = 1'b1; step();
    check("halt_resume", 32'(state_dbg), 32'd1);

    // LDI, SUB, JMP
    mem_ready = 1'b1;
    step(); opcode = 3'd6; mem_ready = 1'b0; #1;
    check("ldi_decode", 32'({ld_ac, ac_src}), 32'(3'b110));
    mem_ready = 1'b1;
    step(); step(); opcode = 3'd3;
    step(); #1;
    check("sub_mem", 32'({state_dbg, ld_ac, ac_src, alu_op}), 32'({3'd3, 4'b1001}));
    step(); step(); opcode = 3'd4; #1;
    check("jmp_decode", 32'({state_dbg, ld_pc, pc_src}), 32'({3'd2, 3'b101}));

    // Asynchronous reset in the middle of a memory access
    step(); step(); opcode = 3'd2; mem_ready = 1'b0;
    step(); #1;
    check("add_mem_req", 32'({state_dbg, mem_req}), 32'({3'd3, 1'b1}));
    rst_n = 1'b0; #1;
    check("reset_mid_mem", 32'(outs), 32'd0);
    step(); step();
    rst_n = 1'b1;
    step(); step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d checks, %0d failures", n_chk, n_fail);
    $fatal(1, "watchdog expired");
  end

endmodule
